// File: rtl/cpu_dbg_pkg.sv
// Shared debug-path types and constants for the CPU register-dump logic.
// The dump FSM state encoding and the PC slot index live here.
package cpu_dbg_pkg;

  localparam int N_DEFAULT = 4;
  localparam int PC_IDX    = 2**N_DEFAULT - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage : cpu_dbg_pkg

// File: rtl/cpu_regfile.sv
// CPU register file: one synchronous write port, one asynchronous read port.
// The dump reader drives the read address while a dump is running.
module cpu_regfile #(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         we,
  input  logic [N-1:0] wa,
  input  logic [M-1:0] wd,
  input  logic [N-1:0] ra,
  output logic [M-1:0] rd
);

  logic [M-1:0] mem [2**N];

  // NOTE: storage arrays get no reset; software initialises registers, and a reset would block RAM mapping.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule : cpu_regfile

// File: rtl/regfile_dump_reader.sv
// Walks every register through the async read port and streams each word with
// its index over valid/ready; the top index carries the live PC from r15.
module regfile_dump_reader
  import cpu_dbg_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic [N-1:0] ra,
  input  logic [M-1:0] rd,
  input  logic [M-1:0] r15,
  output logic [M-1:0] out_data,
  output logic [N-1:0] out_idx,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [N-1:0] LAST_IDX = '1;

  dump_state_t  state, state_nx;
  logic [N-1:0] cnt;
  logic         handshake;
  logic         at_last;

  assign handshake = out_valid & out_ready;
  assign at_last   = (cnt == LAST_IDX);
  assign ra        = cnt;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: the default assignment up front keeps this purely combinational (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && !abort) state_nx = LOAD;
      LOAD: state_nx = abort ? IDLE : SEND;
      SEND: begin
        if (abort)          state_nx = IDLE;
        else if (handshake) state_nx = out_last ? DONE : LOAD;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      LOAD, SEND: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Abort outranks both start and the handshake; IDLE ignores it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (abort && state != IDLE) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) cnt <= '0;
        LOAD: begin
          out_data  <= at_last ? r15 : rd;
          out_idx   <= cnt;
          out_last  <= at_last;
          out_valid <= 1'b1;
        end
        SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (!out_last) cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : regfile_dump_reader

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader driven from the real cpu_regfile.
// Inputs change on the falling edge; outputs are sampled at or just after it.
module tb_regfile_dump_reader;
  import cpu_dbg_pkg::*;

  localparam int N = 4;
  localparam int M = 32;
  localparam int NWORDS = 2**N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort;
  logic [N-1:0] ra;
  logic [M-1:0] rd, r15;
  logic [M-1:0] out_data;
  logic [N-1:0] out_idx;
  logic         out_last, out_valid, out_ready, busy, done;
  logic         rf_we;
  logic [N-1:0] rf_wa;
  logic [M-1:0] rf_wd;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int start_cyc;

  logic [N-1:0] hs_idx [$];
  logic [M-1:0] hs_data[$];
  logic         hs_last[$];
  int           hs_cyc [$];
  int           done_cnt;
  int           done_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_regfile #(.N(N), .M(M)) u_rf (
    .clk (clk), .we (rf_we), .wa (rf_wa), .wd (rf_wd), .ra (ra), .rd (rd)
  );

  regfile_dump_reader #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .ra        (ra),
    .rd        (rd),
    .r15       (r15),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Log every word that will be accepted at the coming rising edge, and every done pulse.
  always @(negedge clk) begin
    #1;
    if (!rst && !abort && out_valid && out_ready) begin
      hs_idx.push_back(out_idx);
      hs_data.push_back(out_data);
      hs_last.push_back(out_last);
      hs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [M-1:0] exp_word(input int i, input logic [M-1:0] pc);
    return (i == PC_IDX) ? pc : 32'hA000_0000 + i;
  endfunction

  task automatic clear_log();
    hs_idx.delete(); hs_data.delete(); hs_last.delete(); hs_cyc.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_cyc = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid_idx(input logic [N-1:0] k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == k) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if ({out_valid, busy, done, out_last} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {out_valid, busy, done, out_last}); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if ({out_idx, ra} !== '0) $display("FAIL reset_idx_ra: got idx %0d ra %0d want 0 0", out_idx, ra); else pass_cnt++;
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk);
      rf_we = 1'b1; rf_wa = N'(i); rf_wd = 32'hA000_0000 + i;
    end
    @(negedge clk);
    rf_we = 1'b0;
    total_cnt++; if ({out_valid, busy, done} !== 3'b0) $display("FAIL reset_held: got %b want 000", {out_valid, busy, done}); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_full_dump();
    bit ok;
    clear_log();
    pulse_start();
    total_cnt++; if (busy !== 1'b1) $display("FAIL full_busy: got %b want 1", busy); else pass_cnt++;
    run_until_done(ok);
    total_cnt++; if (!ok) $display("FAIL full_timeout: done not seen within budget"); else pass_cnt++;
    total_cnt++; if (hs_idx.size() != NWORDS) $display("FAIL full_count: got %0d words want %0d", hs_idx.size(), NWORDS); else pass_cnt++;
    if (hs_idx.size() == NWORDS) begin
      for (int i = 0; i < NWORDS; i++) begin
        total_cnt++;
        if (hs_idx[i] !== N'(i) || hs_data[i] !== exp_word(i, 32'h100) || hs_last[i] !== (i == PC_IDX))
          $display("FAIL full_word%0d: got idx %0d data %h last %b want idx %0d data %h last %b",
                   i, hs_idx[i], hs_data[i], hs_last[i], i, exp_word(i, 32'h100), (i == PC_IDX));
        else pass_cnt++;
        if (i > 0) begin
          total_cnt++; if (hs_cyc[i] - hs_cyc[i-1] != 2) $display("FAIL full_spacing%0d: got %0d want 2", i, hs_cyc[i] - hs_cyc[i-1]); else pass_cnt++;
        end
      end
      total_cnt++; if (hs_cyc[0] - start_cyc != 2) $display("FAIL full_first_latency: got %0d want 2", hs_cyc[0] - start_cyc); else pass_cnt++;
      total_cnt++; if (done_cyc - hs_cyc[NWORDS-1] != 1) $display("FAIL full_done_delay: got %0d want 1", done_cyc - hs_cyc[NWORDS-1]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL full_done_count: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (done_cyc - start_cyc != 2*NWORDS + 1) $display("FAIL full_duration: got %0d want %0d", done_cyc - start_cyc, 2*NWORDS + 1); else pass_cnt++;
    total_cnt++; if ({busy, done, out_valid} !== 3'b0) $display("FAIL full_idle_after: got %b want 000", {busy, done, out_valid}); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int  stall = 0;
    bit  ok = 1'b0;
    clear_log();
    pulse_start();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1'b1; break; end
      if (out_valid && out_idx == 3 && stall < 5) begin
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'hA000_0003)
          $display("FAIL bp_hold%0d: got valid %b data %h want 1 a0000003", stall, out_valid, out_data);
        else pass_cnt++;
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (!ok) $display("FAIL bp_timeout: done not seen within budget"); else pass_cnt++;
    total_cnt++; if (stall != 5) $display("FAIL bp_stall_cycles: got %0d want 5", stall); else pass_cnt++;
    total_cnt++; if (hs_idx.size() != NWORDS) $display("FAIL bp_count: got %0d want %0d", hs_idx.size(), NWORDS); else pass_cnt++;
    if (hs_idx.size() == NWORDS) begin
      total_cnt++; if (hs_idx[4] !== 4'd4 || hs_data[4] !== 32'hA000_0004) $display("FAIL bp_next_word: got idx %0d data %h want 4 a0000004", hs_idx[4], hs_data[4]); else pass_cnt++;
      total_cnt++; if (hs_cyc[3] - hs_cyc[2] != 7) $display("FAIL bp_stall_gap: got %0d want 7", hs_cyc[3] - hs_cyc[2]); else pass_cnt++;
      total_cnt++; if (hs_cyc[4] - hs_cyc[3] != 2) $display("FAIL bp_release_gap: got %0d want 2", hs_cyc[4] - hs_cyc[3]); else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_log();
    pulse_start();
    wait_valid_idx(4'd7, ok);
    total_cnt++; if (!ok) $display("FAIL abort_reach_idx7: timeout"); else pass_cnt++;
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    total_cnt++; if ({out_valid, busy, done} !== 3'b0) $display("FAIL abort_flags: got %b want 000", {out_valid, busy, done}); else pass_cnt++;
    total_cnt++; if (ra !== '0) $display("FAIL abort_ra: got %0d want 0", ra); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_start_in_idle: got busy %b want 0", busy); else pass_cnt++;
    abort = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++; if (done_cnt != 0) $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); else pass_cnt++;
    total_cnt++; if (hs_idx.size() != 7) $display("FAIL abort_words: got %0d want 7", hs_idx.size()); else pass_cnt++;
    clear_log();
    pulse_start();
    run_until_done(ok);
    total_cnt++; if (!ok || hs_idx.size() != NWORDS) $display("FAIL abort_restart_count: got %0d want %0d", hs_idx.size(), NWORDS); else pass_cnt++;
    if (hs_idx.size() > 0) begin
      total_cnt++; if (hs_idx[0] !== '0 || hs_data[0] !== 32'hA000_0000) $display("FAIL abort_restart_first: got idx %0d data %h want 0 a0000000", hs_idx[0], hs_data[0]); else pass_cnt++;
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    clear_log();
    pulse_start();
    wait_valid_idx(4'd2, ok);
    total_cnt++; if (!ok) $display("FAIL busy_reach_idx2: timeout"); else pass_cnt++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until_done(ok);
    total_cnt++; if (!ok || hs_idx.size() != NWORDS) $display("FAIL busy_count: got %0d want %0d", hs_idx.size(), NWORDS); else pass_cnt++;
    if (hs_idx.size() == NWORDS) begin
      for (int i = 0; i < NWORDS; i++) begin
        total_cnt++; if (hs_idx[i] !== N'(i)) $display("FAIL busy_seq%0d: got idx %0d want %0d", i, hs_idx[i], i); else pass_cnt++;
      end
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL busy_done_count: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit ok;
    clear_log();
    pulse_start();
    wait_valid_idx(4'd9, ok);
    total_cnt++; if (!ok) $display("FAIL rst_reach_idx9: timeout"); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if ({out_valid, busy, done} !== 3'b0) $display("FAIL rst_async_flags: got %b want 000", {out_valid, busy, done}); else pass_cnt++;
    total_cnt++; if (out_idx !== '0 || ra !== '0) $display("FAIL rst_async_idx_ra: got idx %0d ra %0d want 0 0", out_idx, ra); else pass_cnt++;
    total_cnt++; if (out_data !== '0 || out_last !== 1'b0) $display("FAIL rst_async_data: got %h last %b want 0 0", out_data, out_last); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (5) @(negedge clk);
    total_cnt++; if (done_cnt != 0 || busy !== 1'b0) $display("FAIL rst_no_done: got done %0d busy %b want 0 0", done_cnt, busy); else pass_cnt++;
  endtask

  task automatic test_r15_change();
    bit ok;
    clear_log();
    pulse_start();
    wait_valid_idx(4'd5, ok);
    total_cnt++; if (!ok) $display("FAIL pc_reach_idx5: timeout"); else pass_cnt++;
    r15 = 32'h0000_0200;
    run_until_done(ok);
    total_cnt++; if (!ok || hs_idx.size() != NWORDS) $display("FAIL pc_count: got %0d want %0d", hs_idx.size(), NWORDS); else pass_cnt++;
    if (hs_idx.size() == NWORDS) begin
      total_cnt++; if (hs_data[PC_IDX] !== 32'h0000_0200 || hs_last[PC_IDX] !== 1'b1)
        $display("FAIL pc_word: got data %h last %b want 00000200 1", hs_data[PC_IDX], hs_last[PC_IDX]);
      else pass_cnt++;
      total_cnt++; if (hs_data[14] !== 32'hA000_000E || hs_last[14] !== 1'b0) $display("FAIL pc_idx14: got data %h last %b want a000000e 0", hs_data[14], hs_last[14]); else pass_cnt++;
    end
    r15 = 32'h0000_0100;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    r15 = 32'h0000_0100;
    rf_we = 1'b0; rf_wa = '0; rf_wd = '0;
    done_cnt = 0; done_cyc = 0; start_cyc = 0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_abort();
    test_start_while_busy();
    test_async_reset();
    test_r15_change();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_regfile_dump_reader
